// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register unit: divider FSM encoding,
// counter sizing and reset value.
package hilo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } hilo_state_e;

    localparam logic HILO_RST_BIT = 1'b0;

    // Counter must hold the value WIDTH itself.
    function automatic int unsigned hilo_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/hilo_div_core.sv
// Iterative restoring divider datapath: operand latch, one quotient bit per
// step, and sign/special-case correction presented combinationally for FIX.
module hilo_div_core
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             last_c
);

    localparam int unsigned CNT_W = hilo_cnt_w(WIDTH);

    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             bzero_q, bzero_d;
    logic             ovf_q, ovf_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;

    always_comb begin
        a_raw_d = a_raw_q;
        b_d     = b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        ovf_d   = ovf_q;

        a_neg   = signed_i & a_i[WIDTH-1];
        b_neg   = signed_i & b_i[WIDTH-1];
        a_mag   = a_neg ? (~a_i + WIDTH'(1)) : a_i;
        b_mag   = b_neg ? (~b_i + WIDTH'(1)) : b_i;
        shifted = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};

        if (load_i) begin
            a_raw_d = a_i;
            b_d     = b_mag;
            quot_d  = a_mag;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            bzero_d = (b_i == '0);
            ovf_d   = signed_i && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
        end else if (step_i) begin
            // Restore (keep the shifted value) when the trial subtraction goes negative.
            if (!trial[WIDTH]) begin
                rem_d  = trial;
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = shifted;
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_raw_q <= '0;
            b_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= HILO_RST_BIT;
            rneg_q  <= HILO_RST_BIT;
            bzero_q <= HILO_RST_BIT;
            ovf_q   <= HILO_RST_BIT;
        end else begin
            a_raw_q <= a_raw_d;
            b_q     <= b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
            ovf_q   <= ovf_d;
        end
    end

    // Final results; divide-by-zero reports the raw dividend in the remainder.
    always_comb begin
        last_c = (cnt_q == CNT_W'(1));
        if (bzero_q) begin
            quot_o = '1;
            rem_o  = a_raw_q;
        end else if (ovf_q) begin
            quot_o = {1'b1, {(WIDTH-1){1'b0}}};
            rem_o  = '0;
        end else begin
            quot_o = qneg_q ? (~quot_q + WIDTH'(1)) : quot_q;
            rem_o  = WIDTH'(rneg_q ? (~rem_q + (WIDTH+1)'(1)) : rem_q);
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with per-half direct writes and an iterative divider.
// Optional MADD/MSUB accumulate path enabled by defining HILO_MADD_EN.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    input  logic             div_cancel,
`ifdef HILO_MADD_EN
    input  logic             acc_we,
    input  logic             acc_sub,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
`endif
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    hilo_state_e      state_q, state_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept_c;
    logic             step_c;
    logic             div_wr_c;
    logic             last_c;
    logic [WIDTH-1:0] quot_c, rem_c;

    assign accept_c = (state_q == ST_IDLE) && div_start && !div_cancel;
    assign step_c   = (state_q == ST_CALC) && !div_cancel;

    hilo_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept_c),
        .step_i   (step_c),
        .signed_i (div_signed),
        .a_i      (div_a),
        .b_i      (div_b),
        .quot_o   (quot_c),
        .rem_o    (rem_c),
        .last_c   (last_c)
    );

    // Divider sequencing; cancel in CALC/FIX drops the divide without writing.
    always_comb begin
        state_d  = state_q;
        div_wr_c = 1'b0;
        unique case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_CALC;
            ST_CALC: begin
                if (div_cancel)  state_d = ST_IDLE;
                else if (last_c) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d  = ST_IDLE;
                div_wr_c = !div_cancel;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

`ifdef HILO_MADD_EN
    logic                 acc_en_c;
    logic [2*WIDTH-1:0]   acc_sum_c;
    assign acc_en_c  = acc_we && !busy_q;
    assign acc_sum_c = acc_sub ? ({hi_q, lo_q} - {acc_hi, acc_lo})
                               : ({hi_q, lo_q} + {acc_hi, acc_lo});
`endif

    // Later assignments win: direct write > divide result > accumulate.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
`ifdef HILO_MADD_EN
        if (acc_en_c) begin
            hi_d = acc_sum_c[2*WIDTH-1:WIDTH];
            lo_d = acc_sum_c[WIDTH-1:0];
        end
`endif
        if (div_wr_c) begin
            hi_d = rem_c;
            lo_d = quot_c;
        end
        if (hi_we) hi_d = hi_i;
        if (lo_we) lo_d = lo_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            busy_q  <= HILO_RST_BIT;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign div_busy = busy_q;
    assign div_done = (state_q == ST_FIX) && !div_cancel;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule
